// File: rtl/semaforo_ssd_ctrl.sv
// Two-way traffic-light controller with pedestrian shortening, maintenance flash
// and a multiplexed seven-segment countdown of the seconds left in the current phase.
module semaforo_ssd_ctrl #(
   parameter int CLK_HZ      = 100000000,
   parameter int REFRESH_DIV = 100000,
   parameter int DIGITS      = 2,
   parameter int GREEN_S     = 25,
   parameter int YELLOW_S    = 4,
   parameter int ALLRED_S    = 2,
   parameter int PED_MIN_S   = 5
) (
   input  logic       CLK100MHZ,
   input  logic       RST,
   input  logic       PED_REQ,
   input  logic       MAINT,
   output logic [2:0] LIGHT_NS,
   output logic [2:0] LIGHT_EW,
   output logic [7:0] AN,
   output logic [6:0] display
);

   localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_HZ - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLK_HZ / 2);
   localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_DIV - 1);
   localparam logic [2:0]    DIG_MAX  = 3'(DIGITS - 1);
   localparam logic [7:0]    GREEN_D  = 8'(GREEN_S);
   localparam logic [7:0]    YELLOW_D = 8'(YELLOW_S);
   localparam logic [7:0]    ALLRED_D = 8'(ALLRED_S);
   localparam logic [7:0]    PED_D    = 8'(PED_MIN_S);
   localparam logic [2:0]    RED      = 3'b100;
   localparam logic [6:0]    DASH     = 7'b1111110;

   typedef enum logic [2:0] {
      ALLRED_A  = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      ALLRED_B  = 3'd3,
      EW_GREEN  = 3'd4,
      EW_YELLOW = 3'd5,
      FLASH     = 3'd6
   } state_t;

   function automatic logic [7:0] duration_f(input state_t st);
      case (st)
         NS_GREEN, EW_GREEN:   duration_f = GREEN_D;
         NS_YELLOW, EW_YELLOW: duration_f = YELLOW_D;
         default:              duration_f = ALLRED_D;
      endcase
   endfunction

   function automatic state_t succ_f(input state_t st);
      case (st)
         ALLRED_A:  succ_f = NS_GREEN;
         NS_GREEN:  succ_f = NS_YELLOW;
         NS_YELLOW: succ_f = ALLRED_B;
         ALLRED_B:  succ_f = EW_GREEN;
         EW_GREEN:  succ_f = EW_YELLOW;
         default:   succ_f = ALLRED_A;
      endcase
   endfunction

   function automatic logic is_green_f(input state_t st);
      is_green_f = (st == NS_GREEN) || (st == EW_GREEN);
   endfunction

   // Returns {NS, EW}; unknown encodings fall back to all red.
   function automatic logic [5:0] lights_f(input state_t st, input logic blink);
      case (st)
         NS_GREEN:  lights_f = {3'b001, RED};
         NS_YELLOW: lights_f = {3'b010, RED};
         EW_GREEN:  lights_f = {RED, 3'b001};
         EW_YELLOW: lights_f = {RED, 3'b010};
         FLASH:     lights_f = {1'b0, blink, 1'b0, 1'b0, blink, 1'b0};
         default:   lights_f = {RED, RED};
      endcase
   endfunction

   function automatic logic [11:0] bcd_f(input logic [7:0] bin);
      logic [19:0] sh;
      sh = {12'd0, bin};
      for (int k = 0; k < 8; k++) begin
         if (sh[11:8] >= 4'd5)  sh[11:8]  = sh[11:8] + 4'd3;
         if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
         if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
         sh = sh << 1;
      end
      bcd_f = sh[19:8];
   endfunction

   function automatic logic [6:0] seg_f(input logic [3:0] d);
      case (d)
         4'd0:    seg_f = 7'b0000001;
         4'd1:    seg_f = 7'b1001111;
         4'd2:    seg_f = 7'b0010010;
         4'd3:    seg_f = 7'b0000110;
         4'd4:    seg_f = 7'b1001100;
         4'd5:    seg_f = 7'b0100100;
         4'd6:    seg_f = 7'b0100000;
         4'd7:    seg_f = 7'b0001111;
         4'd8:    seg_f = 7'b0000000;
         4'd9:    seg_f = 7'b0000100;
         default: seg_f = 7'b1111111;
      endcase
   endfunction

   localparam logic [6:0] RST_SEG = seg_f(4'(ALLRED_S % 10));

   logic [CW-1:0] cnt_r, cnt_nx_s;
   logic          tick_s, blink_nx_s, flash_exit_s;
   logic          ped_meta_r, ped_sync_r, ped_prev_r, ped_rise_s;
   logic          maint_meta_r, maint_sync_r;
   state_t        state_r, state_nx_s;
   logic [7:0]    remain_r, remain_nx_s;
   logic          pending_r, pending_nx_s, advance_s;
   logic [RW-1:0] ref_r;
   logic          ref_wrap_s;
   logic [2:0]    dig_r, dig_nx_s;
   logic [11:0]   bcd_s;
   logic [3:0]    digit_s;
   logic [2:0]    light_ns_r, light_ew_r;
   logic [7:0]    an_r;
   logic [6:0]    seg_r;

   assign tick_s       = (cnt_r == CNT_MAX);
   assign flash_exit_s = (state_r == FLASH) && !maint_sync_r;
   // Leaving maintenance restarts the second so the clearance lasts its full duration.
   assign cnt_nx_s     = (tick_s || flash_exit_s) ? '0 : cnt_r + CW'(1);
   assign blink_nx_s   = (cnt_nx_s < CNT_HALF);
   assign ped_rise_s   = ped_sync_r & ~ped_prev_r;
   assign ref_wrap_s   = (ref_r == REF_MAX);
   assign dig_nx_s     = ref_wrap_s ? ((dig_r == DIG_MAX) ? 3'd0 : dig_r + 3'd1) : dig_r;
   assign bcd_s        = bcd_f(remain_nx_s);

   // Next phase, remaining seconds and pedestrian bookkeeping.
   always_comb begin
      state_nx_s   = state_r;
      remain_nx_s  = remain_r;
      pending_nx_s = pending_r | ped_rise_s;
      advance_s    = 1'b0;
      if (maint_sync_r) begin
         state_nx_s   = FLASH;
         pending_nx_s = 1'b0;
      end else begin
         case (state_r)
            FLASH: begin
               state_nx_s   = ALLRED_B;
               remain_nx_s  = ALLRED_D;
               pending_nx_s = ped_rise_s;
            end
            NS_GREEN, EW_GREEN: begin
               if (pending_r) pending_nx_s = 1'b0;
               else           pending_nx_s = ped_rise_s;
               if (pending_r && (remain_r > PED_D)) begin
                  remain_nx_s = PED_D;
               end else if (tick_s) begin
                  if (remain_r == 8'd1) advance_s = 1'b1;
                  else                  remain_nx_s = remain_r - 8'd1;
               end else begin
                  remain_nx_s = remain_r;
               end
            end
            default: begin
               if (tick_s) begin
                  if (remain_r == 8'd1) advance_s = 1'b1;
                  else                  remain_nx_s = remain_r - 8'd1;
               end else begin
                  remain_nx_s = remain_r;
               end
            end
         endcase
         if (advance_s) begin
            state_nx_s = succ_f(state_r);
            if (is_green_f(state_nx_s) && pending_nx_s) begin
               remain_nx_s  = PED_D;
               pending_nx_s = 1'b0;
            end else begin
               remain_nx_s = duration_f(state_nx_s);
            end
         end else begin
         end
      end
   end

   // Digit of the next countdown value that the next active anode will show.
   always_comb begin
      case (dig_nx_s)
         3'd0:    digit_s = bcd_s[3:0];
         3'd1:    digit_s = bcd_s[7:4];
         3'd2:    digit_s = bcd_s[11:8];
         default: digit_s = 4'd0;
      endcase
   end

   // Second counter and input synchronisers.
   always_ff @(posedge CLK100MHZ or negedge RST) begin
      if (!RST) begin
         cnt_r        <= '0;
         ped_meta_r   <= 1'b0;
         ped_sync_r   <= 1'b0;
         ped_prev_r   <= 1'b0;
         maint_meta_r <= 1'b0;
         maint_sync_r <= 1'b0;
      end else begin
         cnt_r        <= cnt_nx_s;
         ped_meta_r   <= PED_REQ;
         ped_sync_r   <= ped_meta_r;
         ped_prev_r   <= ped_sync_r;
         maint_meta_r <= MAINT;
         maint_sync_r <= maint_meta_r;
      end
   end

   // Phase state and lights; lights are derived from the next state so they track state_r exactly.
   always_ff @(posedge CLK100MHZ or negedge RST) begin
      if (!RST) begin
         state_r    <= ALLRED_A;
         remain_r   <= ALLRED_D;
         pending_r  <= 1'b0;
         light_ns_r <= RED;
         light_ew_r <= RED;
      end else begin
         state_r                  <= state_nx_s;
         remain_r                 <= remain_nx_s;
         pending_r                <= pending_nx_s;
         {light_ns_r, light_ew_r} <= lights_f(state_nx_s, blink_nx_s);
      end
   end

   // Display refresh scan, anodes and segments.
   always_ff @(posedge CLK100MHZ or negedge RST) begin
      if (!RST) begin
         ref_r <= '0;
         dig_r <= 3'd0;
         an_r  <= 8'hFE;
         seg_r <= RST_SEG;
      end else begin
         ref_r <= ref_wrap_s ? '0 : ref_r + RW'(1);
         dig_r <= dig_nx_s;
         an_r  <= ~(8'd1 << dig_nx_s);
         seg_r <= (state_nx_s == FLASH) ? DASH : seg_f(digit_s);
      end
   end

   assign LIGHT_NS = light_ns_r;
   assign LIGHT_EW = light_ew_r;
   assign AN       = an_r;
   assign display  = seg_r;

endmodule

// File: tb/tb_semaforo_ssd_ctrl.sv
// Directed bench for semaforo_ssd_ctrl at CLK_HZ=10, REFRESH_DIV=2: a vector table for
// the normal cycle plus hand sequences for pedestrian, maintenance and reset corners.
module tb_semaforo_ssd_ctrl;

   logic       CLK100MHZ = 1'b0;
   logic       RST       = 1'b0;
   logic       PED_REQ   = 1'b0;
   logic       MAINT     = 1'b0;
   logic [2:0] LIGHT_NS, LIGHT_EW;
   logic [7:0] AN;
   logic [6:0] display;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
   localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
   localparam logic [6:0] DASH = 7'b1111110;

   semaforo_ssd_ctrl #(.CLK_HZ(10), .REFRESH_DIV(2)) dut (
      .CLK100MHZ(CLK100MHZ),
      .RST      (RST),
      .PED_REQ  (PED_REQ),
      .MAINT    (MAINT),
      .LIGHT_NS (LIGHT_NS),
      .LIGHT_EW (LIGHT_EW),
      .AN       (AN),
      .display  (display)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   // Edges since the last reset release.
   always @(posedge CLK100MHZ or negedge RST) begin
      if (!RST) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   typedef struct {
      int         at;
      logic       ped;
      logic       maint;
      logic [2:0] ns;
      logic [2:0] ew;
      logic [7:0] an;
      logic [6:0] seg;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                            input logic [7:0] an, input logic [6:0] seg);
      chk({tag, " ns"},  {5'd0, LIGHT_NS}, {5'd0, ns});
      chk({tag, " ew"},  {5'd0, LIGHT_EW}, {5'd0, ew});
      chk({tag, " an"},  AN, an);
      chk({tag, " seg"}, {1'b0, display}, {1'b0, seg});
   endtask

   task automatic wait_to(input int t);
      if (cyc > t) begin
         checks++;
         errors++;
         $display("FAIL schedule: at cycle %0d, expected at most %0d", cyc, t);
      end
      while (cyc < t) @(negedge CLK100MHZ);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{0,   1'b0, 1'b0, R, R, 8'hFE, S2};
      vecs[1]  = '{19,  1'b0, 1'b0, R, R, 8'hFD, S0};
      vecs[2]  = '{20,  1'b0, 1'b0, G, R, 8'hFE, S5};
      vecs[3]  = '{22,  1'b0, 1'b0, G, R, 8'hFD, S2};
      vecs[4]  = '{269, 1'b0, 1'b0, G, R, 8'hFE, S1};
      vecs[5]  = '{270, 1'b0, 1'b0, Y, R, 8'hFD, S0};
      vecs[6]  = '{272, 1'b0, 1'b0, Y, R, 8'hFE, S4};
      vecs[7]  = '{309, 1'b0, 1'b0, Y, R, 8'hFE, S1};
      vecs[8]  = '{310, 1'b0, 1'b0, R, R, 8'hFD, S0};
      vecs[9]  = '{329, 1'b0, 1'b0, R, R, 8'hFE, S1};
      vecs[10] = '{330, 1'b0, 1'b0, R, G, 8'hFD, S2};
      vecs[11] = '{580, 1'b0, 1'b0, R, Y, 8'hFE, S4};
      vecs[12] = '{620, 1'b0, 1'b0, R, R, 8'hFE, S2};
      vecs[13] = '{640, 1'b0, 1'b0, G, R, 8'hFE, S5};

      repeat (3) @(negedge CLK100MHZ);
      check_out("in_reset", R, R, 8'hFE, S2);
      @(negedge CLK100MHZ);
      RST = 1'b1;

      for (int i = 0; i < 14; i++) begin
         PED_REQ = vecs[i].ped;
         MAINT   = vecs[i].maint;
         wait_to(vecs[i].at);
         check_out($sformatf("vec%0d", i), vecs[i].ns, vecs[i].ew, vecs[i].an, vecs[i].seg);
      end

      // Pedestrian at REMAIN=20 clamps to 5.
      wait_to(690);
      check_out("pedA_pre", G, R, 8'hFD, S2);
      PED_REQ = 1'b1;
      wait_to(696);
      check_out("pedA_clamp", G, R, 8'hFE, S5);
      wait_to(700);
      PED_REQ = 1'b0;
      wait_to(739);
      check_out("pedA_last", G, R, 8'hFD, S0);
      wait_to(740);
      check_out("pedA_exit", Y, R, 8'hFE, S4);
      wait_to(802);
      check_out("pedA_ewg", R, G, 8'hFD, S2);

      // Pedestrian at REMAIN=3 leaves the green unchanged.
      wait_to(1330);
      check_out("pedB_pre", G, R, 8'hFD, S0);
      PED_REQ = 1'b1;
      wait_to(1336);
      check_out("pedB_keep", G, R, 8'hFE, S3);
      wait_to(1340);
      PED_REQ = 1'b0;
      wait_to(1359);
      check_out("pedB_last", G, R, 8'hFD, S0);
      wait_to(1360);
      check_out("pedB_exit", Y, R, 8'hFE, S4);
      wait_to(1422);
      check_out("pedB_ewg", R, G, 8'hFD, S2);

      // Pedestrian during yellow shortens the following green only.
      wait_to(1990);
      check_out("pedC_pre", Y, R, 8'hFD, S0);
      PED_REQ = 1'b1;
      wait_to(1995);
      PED_REQ = 1'b0;
      wait_to(2040);
      check_out("pedC_ewg1", R, G, 8'hFE, S5);
      wait_to(2042);
      check_out("pedC_ewg10", R, G, 8'hFD, S0);
      wait_to(2089);
      check_out("pedC_last", R, G, 8'hFE, S1);
      wait_to(2090);
      check_out("pedC_exit", R, Y, 8'hFD, S0);
      wait_to(2151);
      check_out("pedC_nsg", G, R, 8'hFD, S2);

      // Maintenance flash from EW green.
      wait_to(2500);
      check_out("maint_pre", R, G, 8'hFE, S1);
      MAINT = 1'b1;
      for (int n = 2503; n <= 2512; n++) begin
         logic       b;
         logic [2:0] fl;
         wait_to(n);
         b  = ((n % 10) < 5);
         fl = {1'b0, b, 1'b0};
         check_out($sformatf("flash%0d", n), fl, fl, ((n / 2) % 2 == 1) ? 8'hFD : 8'hFE, DASH);
      end
      wait_to(2520);
      check_out("flash_end", Y, Y, 8'hFE, DASH);
      MAINT = 1'b0;
      wait_to(2522);
      check_out("flash_hold", Y, Y, 8'hFD, DASH);
      wait_to(2523);
      check_out("maint_allred", R, R, 8'hFD, S0);
      wait_to(2542);
      check_out("maint_allred_end", R, R, 8'hFD, S0);
      wait_to(2543);
      check_out("maint_ewg", R, G, 8'hFD, S2);

      // Asynchronous reset in the middle of a digit slot.
      wait_to(2547);
      check_out("rst_pre", R, G, 8'hFD, S2);
      #2;
      RST = 1'b0;
      #1;
      check_out("rst_mid", R, R, 8'hFE, S2);
      @(negedge CLK100MHZ);
      RST = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
